coinc_acq_sequencer: RTL and testbench
======================================

# coinc_acq_sequencer

Acquisition sequencer for the coincidence detector datapath. It runs timed gate windows: clear the detector, enable it for a programmed number of cycles, wait for its pipeline to drain, then latch the coincidence count into a one-entry result register with a valid/ready handshake. It sits between the AXI-Lite register bank (which supplies configuration and start/abort pulses and reads results) and the detector core (which it drives through `det_clear` and `det_enable`).

## Interface
Parameters:
- `CNT_W`, 32, width of the detector count and the result count.
- `WIN_W`, 32, width of the gate-window length.
- `ID_W`, 16, width of the window sequence ID.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_window`  in  WIN_W  gate length in clock cycles; 0 is treated as 1.
- `cfg_repeat`  in  1  1 = continuous back-to-back windows; 0 = single shot.
- `start`  in  1  one-cycle pulse that begins acquisition.
- `abort`  in  1  one-cycle pulse that stops acquisition with no result.
- `det_clear`  out  1  clears the detector count.
- `det_enable`  out  1  gates detector counting.
- `det_count`  in  CNT_W  running detector coincidence count.
- `res_valid`  out  1  result register holds an unread result.
- `res_ready`  in  1  consumer accepts the result.
- `res_count`  out  CNT_W  latched count.
- `res_id`  out  ID_W  sequence number of the latched window.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `overrun`  out  1  sticky flag: a result was dropped.

## Operation
- FSM states: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE → CLEAR when `start`=1 and `abort`=0. `start` in any other state is ignored.
- CLEAR (1 cycle):
  - `det_clear`=1.
  - Sample `cfg_window` into `win_len` (0 is stored as 1). `cfg_window` changes take effect only at the next CLEAR.
  - Load the window counter with `win_len`-1.
- GATE (`win_len` cycles): `det_enable`=1; the counter decrements. Go to SETTLE when the counter reaches 0.
- SETTLE (exactly 2 cycles): covers the detector pipeline latency. `det_enable`=0.
- LATCH (1 cycle):
  - If `res_valid`=0 or a handshake completes this cycle: capture `det_count` into `res_count`, load the window ID counter into `res_id`, set `res_valid`.
  - Otherwise drop the result and set `overrun`. The result register is left unchanged.
  - The window ID counter increments in both cases; it wraps from 2^ID_W-1 to 0.
  - Next state is CLEAR if `cfg_repeat`=1, else IDLE.
- Handshake: `res_valid` clears on a cycle with `res_valid` && `res_ready`. `res_count` and `res_id` are stable while `res_valid`=1.
- `abort` in any non-IDLE state:
  - Next state is IDLE and `det_enable` drops on the next cycle.
  - If the FSM is in LATCH, the capture still happens this cycle, but a repeat is not started.
  - The result register is untouched.
- `start` accepted from IDLE clears `overrun` and resets the window ID counter to 0.
- `start` and `abort` in the same cycle in IDLE: `abort` wins and the FSM stays in IDLE.
- `det_clear`, `det_enable` and `busy` are Moore outputs decoded from registered state, with no combinational path from inputs.

## Timing
- Reset values: state IDLE; `det_clear`, `det_enable`, `busy`, `res_valid`, `overrun` all 0; `res_count` 0; `res_id` 0; ID counter 0.
- `start` sampled at edge k puts the FSM in:
  - CLEAR during cycle k+1;
  - GATE during cycles k+2 .. k+1+W;
  - SETTLE during cycles k+2+W and k+3+W;
  - LATCH during cycle k+4+W.
- `res_valid` is high from cycle k+5+W, so start-to-result latency is W+5 cycles.
- Repeat-mode period is W+4 cycles from one CLEAR to the next.
- `reset` mid-operation returns everything to reset values on the next edge and discards any pending result.

## Test plan
- Single shot: W=10, `det_count` held at 7, `res_ready`=1 → `det_enable` high exactly 10 cycles, `res_valid` first high 15 cycles after `start`, `res_count`=7, `res_id`=0, `busy` low afterwards.
- `cfg_window`=0: `start` → GATE lasts 1 cycle, `res_valid` 6 cycles after `start`.
- Repeat mode: W=4, `res_ready`=0 → first result kept (`res_id`=0), `overrun`=1 after the second LATCH, `res_id` still 0. Then `res_ready`=1 for one cycle → the next LATCH delivers `res_id`=2.
- Abort: `abort` on the 3rd GATE cycle → `det_enable` low on the next cycle, FSM in IDLE, `res_valid` stays 0. A following `start` runs normally.
- Reset mid-SETTLE with `res_valid`=1 from a prior window → every output 0 on the next cycle.
- ID wrap (ID_W=2, repeat, `res_ready`=1): `res_id` sequence 0,1,2,3,0. `start`+`abort` together in IDLE → `busy` stays 0.

Source files
------------

// File: rtl/coinc_acq_sequencer.sv
// Acquisition sequencer for the coincidence detector: runs timed gate windows
// (clear, gate, settle, latch) and holds one result behind a valid/ready port.
module coinc_acq_sequencer #(
  parameter int CNT_W = 32,
  parameter int WIN_W = 32,
  parameter int ID_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             cfg_repeat,
  input  logic             start,
  input  logic             abort,
  output logic             det_clear,
  output logic             det_enable,
  input  logic [CNT_W-1:0] det_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [ID_W-1:0]  res_id,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIN_W-1:0] win_cnt;
  logic             settle_cnt;
  logic [ID_W-1:0]  id_cnt;
  logic [WIN_W-1:0] win_len;
  logic             handshake;

  // A zero-length window is promoted to one gate cycle.
  assign win_len   = (cfg_window == '0) ? {{(WIN_W-1){1'b0}}, 1'b1} : cfg_window;
  assign handshake = res_valid && res_ready;

  // Moore outputs decoded purely from the registered state.
  assign det_clear  = (state == CLEAR);
  assign det_enable = (state == GATE);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; abort from any active state returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start && !abort) state_next = CLEAR;
      CLEAR:  state_next = abort ? IDLE : GATE;
      GATE: begin
        if (abort)              state_next = IDLE;
        else if (win_cnt == '0) state_next = SETTLE;
      end
      SETTLE: begin
        if (abort)           state_next = IDLE;
        else if (settle_cnt) state_next = LATCH;
      end
      LATCH:  state_next = (cfg_repeat && !abort) ? CLEAR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Window/settle counters, window ID, result register and overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      win_cnt    <= '0;
      settle_cnt <= 1'b0;
      id_cnt     <= '0;
      res_valid  <= 1'b0;
      res_count  <= '0;
      res_id     <= '0;
      overrun    <= 1'b0;
    end else begin
      if (handshake) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            overrun <= 1'b0;
            id_cnt  <= '0;
          end
        end
        CLEAR: begin
          win_cnt    <= win_len - 1'b1;
          settle_cnt <= 1'b0;
        end
        GATE: begin
          if (win_cnt != '0) win_cnt <= win_cnt - 1'b1;
          settle_cnt <= 1'b0;
        end
        SETTLE: settle_cnt <= ~settle_cnt;
        LATCH: begin
          // Capture still happens on abort; only the repeat is suppressed.
          if (!res_valid || handshake) begin
            res_count <= det_count;
            res_id    <= id_cnt;
            res_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          id_cnt <= id_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coinc_acq_sequencer.sv
// Directed bench for coinc_acq_sequencer with a result scoreboard.
module tb_coinc_acq_sequencer;

  localparam int CNT_W = 32;
  localparam int WIN_W = 32;
  localparam int ID_W  = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIN_W-1:0] cfg_window = '0;
  logic             cfg_repeat = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             det_clear;
  logic             det_enable;
  logic [CNT_W-1:0] det_count = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [CNT_W-1:0] res_count;
  logic [ID_W-1:0]  res_id;
  logic             busy;
  logic             overrun;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  coinc_acq_sequencer #(.CNT_W(CNT_W), .WIN_W(WIN_W), .ID_W(ID_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_window (cfg_window),
    .cfg_repeat (cfg_repeat),
    .start      (start),
    .abort      (abort),
    .det_clear  (det_clear),
    .det_enable (det_enable),
    .det_count  (det_count),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .res_id     (res_id),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [CNT_W-1:0] c, input logic [ID_W-1:0] id);
    exp_t e;
    e.cnt = c;
    e.id  = id;
    exp_q.push_back(e);
  endtask

  // Pulse start and run n cycles, counting gate cycles and first valid cycle.
  task automatic run_window(input int n, output int en, output int first);
    en = 0;
    first = 0;
    start = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (i == 1) start = 1'b0;
      if (det_enable) en++;
      if (res_valid && first == 0) first = i;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " det_clear"},  64'(det_clear),  64'd0);
    check({tag, " det_enable"}, 64'(det_enable), 64'd0);
    check({tag, " busy"},       64'(busy),       64'd0);
    check({tag, " res_valid"},  64'(res_valid),  64'd0);
    check({tag, " overrun"},    64'(overrun),    64'd0);
    check({tag, " res_count"},  64'(res_count),  64'd0);
    check({tag, " res_id"},     64'(res_id),     64'd0);
  endtask

  // Monitor: every accepted result is popped and compared against the queue.
  always @(negedge clock) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected result", 64'(res_count), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_count", 64'(res_count), 64'(e.cnt));
        check("res_id",    64'(res_id),    64'(e.id));
      end
    end
  end

  initial begin
    int en, first, seen;

    // Reset state
    tick(2);
    reset = 1'b0;
    check_all_zero("reset");

    // Single shot, W=10
    cfg_window = 10; det_count = 7; res_ready = 1'b1; cfg_repeat = 1'b0;
    push(7, 0);
    run_window(25, en, first);
    check("w10 gate cycles", 64'(en), 64'd10);
    check("w10 latency", 64'(first), 64'd15);
    check("w10 busy after", 64'(busy), 64'd0);
    check("w10 overrun", 64'(overrun), 64'd0);

    // Zero window behaves as one cycle
    cfg_window = 0; det_count = 3;
    push(3, 0);
    run_window(12, en, first);
    check("w0 gate cycles", 64'(en), 64'd1);
    check("w0 latency", 64'(first), 64'd6);

    // Repeat mode, W=4, consumer stalled
    cfg_window = 4; cfg_repeat = 1'b1; res_ready = 1'b0; det_count = 5;
    push(5, 0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(8);
    check("rep first valid", 64'(res_valid), 64'd1);
    check("rep first id", 64'(res_id), 64'd0);
    check("rep overrun early", 64'(overrun), 64'd0);
    det_count = 9;
    tick(8);
    check("rep overrun set", 64'(overrun), 64'd1);
    check("rep id held", 64'(res_id), 64'd0);
    check("rep count held", 64'(res_count), 64'd5);
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    check("rep valid cleared", 64'(res_valid), 64'd0);
    det_count = 11;
    push(11, 2);
    tick(7);
    check("rep third valid", 64'(res_valid), 64'd1);
    check("rep third id", 64'(res_id), 64'd2);
    res_ready = 1'b1; abort = 1'b1;
    tick(1);
    abort = 1'b0; cfg_repeat = 1'b0;
    check("rep abort busy", 64'(busy), 64'd0);
    tick(2);

    // Abort on the third gate cycle
    cfg_window = 10; det_count = 13;
    start = 1'b1; tick(1); start = 1'b0;
    tick(3);
    check("abort gate active", 64'(det_enable), 64'd1);
    abort = 1'b1; tick(1); abort = 1'b0;
    check("abort det_enable", 64'(det_enable), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort overrun cleared", 64'(overrun), 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (res_valid) seen++;
    end
    check("abort no result", 64'(seen), 64'd0);
    cfg_window = 2; det_count = 4;
    push(4, 0);
    run_window(12, en, first);
    check("post-abort gate cycles", 64'(en), 64'd2);
    check("post-abort latency", 64'(first), 64'd7);

    // Reset during SETTLE with a pending result
    cfg_window = 3; res_ready = 1'b0; det_count = 6;
    start = 1'b1; tick(1); start = 1'b0;
    tick(7);
    check("pending valid", 64'(res_valid), 64'd1);
    check("pending count", 64'(res_count), 64'd6);
    start = 1'b1; tick(1); start = 1'b0;
    tick(4);
    check("settle busy", 64'(busy), 64'd1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check_all_zero("midreset");

    // ID wrap with ID_W=2
    cfg_window = 1; cfg_repeat = 1'b1; res_ready = 1'b1; det_count = 8;
    push(8, 0); push(8, 1); push(8, 2); push(8, 3); push(8, 0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(25);
    abort = 1'b1; tick(1); abort = 1'b0; cfg_repeat = 1'b0;
    tick(3);
    check("wrap all delivered", 64'(exp_q.size()), 64'd0);
    check("wrap busy", 64'(busy), 64'd0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; tick(1);
    start = 1'b0; abort = 1'b0;
    check("start+abort busy", 64'(busy), 64'd0);
    check("start+abort clear", 64'(det_clear), 64'd0);
    tick(1);
    check("start+abort busy later", 64'(busy), 64'd0);

    check("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
